// File: rtl/thread_scheduler_if.sv
// Handshake bundle between the vector core and the thread scheduler.
// The core side uses the master modport, the scheduler uses slave.
interface thread_scheduler_if #(
    parameter int NUM_THREADS = 8,
    parameter int PC_WIDTH    = 32
);
    localparam int TID_WIDTH = $clog2(NUM_THREADS);

    logic                 spawn_valid;
    logic [PC_WIDTH-1:0]  spawn_pc;
    logic                 spawn_ready;
    logic [TID_WIDTH-1:0] spawn_tid;

    logic                 issue_valid;
    logic                 issue_ready;
    logic [TID_WIDTH-1:0] issue_tid;
    logic [PC_WIDTH-1:0]  issue_pc;

    logic                 retire_valid;
    logic [TID_WIDTH-1:0] retire_tid;
    logic [1:0]           retire_op;
    logic [PC_WIDTH-1:0]  retire_pc;

    logic                 mem_done_valid;
    logic [TID_WIDTH-1:0] mem_done_tid;

    logic [TID_WIDTH:0]   active_count;
    logic                 err;

    modport master (
        output spawn_valid, spawn_pc, issue_ready,
        output retire_valid, retire_tid, retire_op, retire_pc,
        output mem_done_valid, mem_done_tid,
        input  spawn_ready, spawn_tid, issue_valid, issue_tid, issue_pc,
        input  active_count, err
    );

    modport slave (
        input  spawn_valid, spawn_pc, issue_ready,
        input  retire_valid, retire_tid, retire_op, retire_pc,
        input  mem_done_valid, mem_done_tid,
        output spawn_ready, spawn_tid, issue_valid, issue_tid, issue_pc,
        output active_count, err
    );
endinterface

// File: rtl/thread_scheduler.sv
// Hardware-thread scheduler: allocates IDLE contexts on spawn and offers
// READY contexts round-robin to the issue stage; retire/mem_done move state.
module thread_scheduler #(
    parameter int NUM_THREADS = 8,
    parameter int PC_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    thread_scheduler_if.slave      bus
);
    localparam int TID_WIDTH = $clog2(NUM_THREADS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_READY   = 2'b01,
        ST_RUNNING = 2'b10,
        ST_WAIT    = 2'b11
    } ctxState_t;

    ctxState_t            r_state [NUM_THREADS];
    logic [PC_WIDTH-1:0]  r_pc    [NUM_THREADS];
    logic [TID_WIDTH-1:0] r_rrPtr;
    logic                 r_err;
    logic [TID_WIDTH:0]   r_activeCount;

    logic                 w_spawnReady;
    logic [TID_WIDTH-1:0] w_spawnTid;
    logic                 w_issueValid;
    logic [TID_WIDTH-1:0] w_issueOffset;
    logic [TID_WIDTH-1:0] w_issueTid;
    logic                 w_spawnFire;
    logic                 w_issueFire;
    logic                 w_retireLegal;
    logic                 w_retireErr;
    logic                 w_exitFire;
    logic                 w_memLegal;
    logic                 w_memErr;

    // Lowest-numbered IDLE context is the allocation candidate.
    always_comb begin
        w_spawnReady = 1'b0;
        w_spawnTid   = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (r_state[i] == ST_IDLE) begin
                w_spawnReady = 1'b1;
                w_spawnTid   = TID_WIDTH'(i);
            end
        end
    end

    // First READY context at or after rr_ptr; index arithmetic wraps because NUM_THREADS is a power of two.
    always_comb begin
        w_issueValid  = 1'b0;
        w_issueOffset = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (r_state[r_rrPtr + TID_WIDTH'(i)] == ST_READY) begin
                w_issueValid  = 1'b1;
                w_issueOffset = TID_WIDTH'(i);
            end
        end
    end

    assign w_issueTid = r_rrPtr + w_issueOffset;

    assign w_spawnFire   = bus.spawn_valid && w_spawnReady;
    assign w_issueFire   = bus.issue_ready && w_issueValid;
    assign w_retireLegal = bus.retire_valid && (bus.retire_op != 2'b11)
                           && (r_state[bus.retire_tid] == ST_RUNNING);
    assign w_retireErr   = bus.retire_valid && !w_retireLegal;
    assign w_exitFire    = w_retireLegal && (bus.retire_op == 2'b10);
    assign w_memLegal    = bus.mem_done_valid && (r_state[bus.mem_done_tid] == ST_WAIT);
    assign w_memErr      = bus.mem_done_valid && !w_memLegal;

    // Each event can only hit a context in one particular state, so the
    // per-context updates below never collide within a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                r_state[i] <= ST_IDLE;
                r_pc[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (w_spawnFire && (w_spawnTid == TID_WIDTH'(i))) begin
                    r_state[i] <= ST_READY;
                    r_pc[i]    <= bus.spawn_pc;
                end
                if (w_issueFire && (w_issueTid == TID_WIDTH'(i))) begin
                    r_state[i] <= ST_RUNNING;
                end
                if (w_retireLegal && (bus.retire_tid == TID_WIDTH'(i))) begin
                    case (bus.retire_op)
                        2'b00: begin
                            r_state[i] <= ST_READY;
                            r_pc[i]    <= bus.retire_pc;
                        end
                        2'b01: begin
                            r_state[i] <= ST_WAIT;
                            r_pc[i]    <= bus.retire_pc;
                        end
                        default: r_state[i] <= ST_IDLE;
                    endcase
                end
                if (w_memLegal && (bus.mem_done_tid == TID_WIDTH'(i))) begin
                    r_state[i] <= ST_READY;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrPtr       <= '0;
            r_err         <= 1'b0;
            r_activeCount <= '0;
        end else begin
            if (w_issueFire) begin
                r_rrPtr <= w_issueTid + TID_WIDTH'(1);
            end
            if (w_retireErr || w_memErr) begin
                r_err <= 1'b1;
            end
            r_activeCount <= r_activeCount + (TID_WIDTH + 1)'(w_spawnFire)
                                           - (TID_WIDTH + 1)'(w_exitFire);
        end
    end

    assign bus.spawn_ready  = w_spawnReady;
    assign bus.spawn_tid    = w_spawnTid;
    assign bus.issue_valid  = w_issueValid;
    assign bus.issue_tid    = w_issueValid ? w_issueTid : '0;
    assign bus.issue_pc     = w_issueValid ? r_pc[w_issueTid] : '0;
    assign bus.active_count = r_activeCount;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: a behavioural context model is
// compared on every falling edge, plus hand-computed literal expectations.
module tb_thread_scheduler;
    localparam int N   = 8;
    localparam int PCW = 32;
    localparam int M_IDLE  = 0;
    localparam int M_READY = 1;
    localparam int M_RUN   = 2;
    localparam int M_WAIT  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    thread_scheduler_if #(.NUM_THREADS(N), .PC_WIDTH(PCW)) bus ();

    thread_scheduler #(.NUM_THREADS(N), .PC_WIDTH(PCW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: per-context state/pc, arbiter start point, sticky error.
    int          mState [N];
    logic [31:0] mPc    [N];
    int          mRr;
    logic        mErr;

    int          expSpawnReady, expSpawnTid, expIssueValid, expIssueTid, expCount;
    logic [31:0] expIssuePc;

    always_comb begin
        expSpawnReady = 0;
        expSpawnTid   = 0;
        expIssueValid = 0;
        expIssueTid   = 0;
        expIssuePc    = '0;
        expCount      = 0;
        for (int t = N - 1; t >= 0; t--) begin
            if (mState[t] == M_IDLE) begin
                expSpawnReady = 1;
                expSpawnTid   = t;
            end
        end
        for (int t = 0; t < N; t++) begin
            if (mState[t] != M_IDLE) expCount++;
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (mState[(mRr + k) % N] == M_READY) begin
                expIssueValid = 1;
                expIssueTid   = (mRr + k) % N;
            end
        end
        if (expIssueValid != 0) expIssuePc = mPc[expIssueTid];
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < N; t++) begin
                mState[t] <= M_IDLE;
                mPc[t]    <= '0;
            end
            mRr  <= 0;
            mErr <= 1'b0;
        end else begin
            if (bus.spawn_valid && expSpawnReady != 0) begin
                mState[expSpawnTid] <= M_READY;
                mPc[expSpawnTid]    <= bus.spawn_pc;
            end
            if (bus.issue_ready && expIssueValid != 0) begin
                mState[expIssueTid] <= M_RUN;
                mRr <= (expIssueTid + 1) % N;
            end
            if (bus.retire_valid) begin
                if (bus.retire_op == 2'b11 || mState[int'(bus.retire_tid)] != M_RUN) begin
                    mErr <= 1'b1;
                end else if (bus.retire_op == 2'b00) begin
                    mState[int'(bus.retire_tid)] <= M_READY;
                    mPc[int'(bus.retire_tid)]    <= bus.retire_pc;
                end else if (bus.retire_op == 2'b01) begin
                    mState[int'(bus.retire_tid)] <= M_WAIT;
                    mPc[int'(bus.retire_tid)]    <= bus.retire_pc;
                end else begin
                    mState[int'(bus.retire_tid)] <= M_IDLE;
                end
            end
            if (bus.mem_done_valid) begin
                if (mState[int'(bus.mem_done_tid)] != M_WAIT) mErr <= 1'b1;
                else mState[int'(bus.mem_done_tid)] <= M_READY;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Outputs depend only on registered state, so every falling edge is a valid sample point.
    always @(negedge clk) begin
        checkOutput("model spawn_ready", 64'(bus.spawn_ready), 64'(expSpawnReady));
        checkOutput("model spawn_tid", 64'(bus.spawn_tid), 64'(expSpawnTid));
        checkOutput("model issue_valid", 64'(bus.issue_valid), 64'(expIssueValid));
        checkOutput("model issue_tid", 64'(bus.issue_tid), 64'(expIssueTid));
        checkOutput("model issue_pc", 64'(bus.issue_pc), 64'(expIssuePc));
        checkOutput("model active_count", 64'(bus.active_count), 64'(expCount));
        checkOutput("model err", 64'(bus.err), 64'(mErr));
    end

    task automatic applyStimulus(input logic sv, input logic [31:0] spc, input logic ir,
                                 input logic rv, input int rtid, input logic [1:0] rop,
                                 input logic [31:0] rpc, input logic mv, input int mtid);
        @(posedge clk);
        #1;
        bus.spawn_valid    = sv;
        bus.spawn_pc       = spc;
        bus.issue_ready    = ir;
        bus.retire_valid   = rv;
        bus.retire_tid     = 3'(rtid);
        bus.retire_op      = rop;
        bus.retire_pc      = rpc;
        bus.mem_done_valid = mv;
        bus.mem_done_tid   = 3'(mtid);
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.spawn_valid    = 1'b0;
        bus.issue_ready    = 1'b0;
        bus.retire_valid   = 1'b0;
        bus.mem_done_valid = 1'b0;
        #1;
        checkOutput("async reset active_count", 64'(bus.active_count), 64'd0);
        checkOutput("async reset issue_valid", 64'(bus.issue_valid), 64'd0);
        checkOutput("async reset err", 64'(bus.err), 64'd0);
        checkOutput("async reset spawn_ready", 64'(bus.spawn_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int order3 [7] = '{0, 1, 2, 4, 5, 6, 7};

    initial begin
        bus.spawn_valid    = 1'b0;
        bus.spawn_pc       = '0;
        bus.issue_ready    = 1'b0;
        bus.retire_valid   = 1'b0;
        bus.retire_tid     = '0;
        bus.retire_op      = 2'b00;
        bus.retire_pc      = '0;
        bus.mem_done_valid = 1'b0;
        bus.mem_done_tid   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset spawn_ready", 64'(bus.spawn_ready), 64'd1);
        checkOutput("reset spawn_tid", 64'(bus.spawn_tid), 64'd0);
        checkOutput("reset issue_valid", 64'(bus.issue_valid), 64'd0);
        checkOutput("reset issue_pc", 64'(bus.issue_pc), 64'd0);
        checkOutput("reset active_count", 64'(bus.active_count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill all eight contexts back-to-back.
        for (int i = 0; i < N; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
            checkOutput("fill spawn_tid", 64'(bus.spawn_tid), 64'(i));
        end
        idleCycle();
        checkOutput("full spawn_ready", 64'(bus.spawn_ready), 64'd0);
        checkOutput("full active_count", 64'(bus.active_count), 64'd8);

        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
            checkOutput("rr issue_tid", 64'(bus.issue_tid), 64'(k));
            checkOutput("rr issue_pc", 64'(bus.issue_pc), 64'(32'h100 + 32'(k)));
        end
        idleCycle();
        checkOutput("all running issue_valid", 64'(bus.issue_valid), 64'd0);

        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, k, 2'b00, 32'h104 + 32'(k), 1'b0, 0);
        end
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
            checkOutput("reissue tid", 64'(bus.issue_tid), 64'(k));
            checkOutput("reissue pc", 64'(bus.issue_pc), 64'(32'h104 + 32'(k)));
        end

        // Thread 3 waits for memory and must be skipped until mem_done.
        for (int k = 0; k < N; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, k, (k == 3) ? 2'b01 : 2'b00,
                          (k == 3) ? 32'h200 : 32'h108 + 32'(k), 1'b0, 0);
        end
        for (int j = 0; j < 7; j++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
            checkOutput("wait-skip issue_tid", 64'(bus.issue_tid), 64'(order3[j]));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 1'b1, 3);
        checkOutput("waiting issue_valid", 64'(bus.issue_valid), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
        checkOutput("woken issue_tid", 64'(bus.issue_tid), 64'd3);
        checkOutput("woken issue_pc", 64'(bus.issue_pc), 64'h200);

        // Exit of thread 5 together with a held spawn request.
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b1, 5, 2'b10, 32'h0, 1'b0, 0);
        checkOutput("exit+spawn spawn_ready", 64'(bus.spawn_ready), 64'd0);
        checkOutput("exit+spawn active_count", 64'(bus.active_count), 64'd8);
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
        checkOutput("respawn spawn_tid", 64'(bus.spawn_tid), 64'd5);
        checkOutput("respawn active_count", 64'(bus.active_count), 64'd7);
        idleCycle();
        checkOutput("respawned active_count", 64'(bus.active_count), 64'd8);
        checkOutput("respawned issue_pc", 64'(bus.issue_pc), 64'h500);

        // Retire on an IDLE context.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 6, 2'b10, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 6, 2'b00, 32'h999, 1'b0, 0);
        checkOutput("pre-error err", 64'(bus.err), 64'd0);
        idleCycle();
        checkOutput("idle retire err", 64'(bus.err), 64'd1);
        checkOutput("idle retire spawn_tid", 64'(bus.spawn_tid), 64'd6);
        checkOutput("idle retire active_count", 64'(bus.active_count), 64'd7);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1, 2'b01, 32'h600, 1'b0, 0);
        idleCycle();
        checkOutput("sticky err", 64'(bus.err), 64'd1);
        doReset();

        // mem_done on a RUNNING context.
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
        checkOutput("e2 issue_pc", 64'(bus.issue_pc), 64'h700);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 0, 2'b00, 32'h0, 1'b1, 0);
        idleCycle();
        checkOutput("mem_done err", 64'(bus.err), 64'd1);
        checkOutput("mem_done keeps running", 64'(bus.issue_valid), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 0, 2'b00, 32'h704, 1'b0, 0);
        idleCycle();
        checkOutput("e2 yield issue_pc", 64'(bus.issue_pc), 64'h704);
        doReset();

        // Reserved retire op.
        applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 0, 2'b00, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 0, 2'b11, 32'h900, 1'b0, 0);
        idleCycle();
        checkOutput("op11 err", 64'(bus.err), 64'd1);
        checkOutput("op11 active_count", 64'(bus.active_count), 64'd1);
        checkOutput("op11 issue_valid", 64'(bus.issue_valid), 64'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 0, 2'b00, 32'h804, 1'b0, 0);
        idleCycle();
        checkOutput("op11 then yield issue_pc", 64'(bus.issue_pc), 64'h804);
        checkOutput("op11 sticky err", 64'(bus.err), 64'd1);

        idleCycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
